sram_mem_responder: RTL and testbench
=====================================

# sram_mem_responder

Responder side of the pipeline's data-memory interface: accepts the read/write request the MEM stage presents (`mem_read`/`mem_write`, 32-bit address, 32-bit store data) and services it against an external 16-bit-wide asynchronous SRAM. Each 32-bit word is moved as two 16-bit halves, each held for a fixed number of wait cycles. `ready` tells the pipeline when the result is valid; the hazard/freeze logic stalls all stages while `ready` is low.

## Interface
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `WAIT_CYCLES`, default 3: cycles each 16-bit half is held on the SRAM bus; legal range 1..15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_read` in 1: read request; held stable until `ready`.
- `mem_write` in 1: write request; held stable until `ready`.
- `address` in 32: byte address, word-aligned.
- `write_data` in 32: store data; held stable with `mem_write`.
- `read_data` out 32: registered load result.
- `ready` out 1: request complete, or idle with no request.
- `sram_addr` out 18: SRAM halfword address.
- `sram_dq_out` out 16: SRAM write data.
- `sram_dq_oe` out 1: drive enable for `sram_dq_out`; the top level builds the tristate.
- `sram_dq_in` in 16: SRAM read data.
- `sram_we_n` out 1: active-low SRAM write strobe.

## Operation
- FSM states: IDLE, LOW, HIGH, DONE. Wait counter `cnt` is 4 bits.
- IDLE: if `mem_write | mem_read`, latch the request kind, go to LOW, clear `cnt`. Otherwise stay in IDLE.
- Write has priority over read when both are asserted; this is treated as a write only.
- LOW / HIGH:
  - `cnt` increments each cycle.
  - When `cnt == WAIT_CYCLES-1`, clear `cnt` and advance (LOW→HIGH, HIGH→DONE).
- DONE: lasts one cycle, then returns to IDLE unconditionally.
- Address arithmetic:
  - `idx = (address - BASE_ADDR) >> 2`, truncated to 17 bits. Wrap on truncation is accepted; there is no range check.
  - `sram_addr = {idx, 0}` in LOW and `{idx, 1}` in HIGH.
  - `sram_addr` holds 0 in IDLE and DONE.
- Write:
  - `sram_dq_out` = `write_data[15:0]` in LOW and `write_data[31:16]` in HIGH.
  - `sram_dq_oe` = 1 and `sram_we_n` = 0 throughout LOW and HIGH.
- Read:
  - `sram_dq_oe` = 0 and `sram_we_n` = 1.
  - `sram_dq_in` is captured into `read_data[15:0]` on the edge ending LOW's last cycle, and into `read_data[31:16]` on the edge ending HIGH's last cycle.
  - `read_data` holds its value until the next read overwrites it.
  - Writes never change `read_data`.
- `ready` (combinational) = `(IDLE & ~mem_read & ~mem_write) | DONE`.
- Reset, including in the middle of an access:
  - State returns to IDLE; `cnt` = 0; `read_data` = 0.
  - Outputs: `sram_we_n` = 1, `sram_dq_oe` = 0, `sram_addr` = 0, `sram_dq_out` = 0, `ready` = 1 unless a request is asserted.
  - A write aborted by reset may leave the SRAM partially written; this is accepted.

## Timing
- Let cycle 0 be the first cycle in which a request is seen in IDLE. `ready` = 0 in cycle 0.
- LOW occupies cycles 1..W and HIGH occupies cycles W+1..2W, where W = `WAIT_CYCLES`.
- DONE is cycle 2W+1, with `ready` = 1.
- Total latency is 2W+1 cycles; with W = 3, `ready` rises in cycle 7.
- The requester samples `read_data` and advances on the edge ending DONE.
- A new request seen in the following IDLE cycle starts a fresh access. Minimum spacing between accesses is therefore 2W+2 cycles.
- Back-to-back requests never skip IDLE.
- If request inputs change mid-access, the behaviour is undefined. Assertion: inputs stable while `ready` = 0.

## Structure
- Shared package/header `mem_if_defs` holds:
  - state encodings (2 bits);
  - `SRAM_AW = 18` and `SRAM_DW = 16`;
  - the default `BASE_ADDR`.
- The MEM stage and the top-level SRAM pin wrapper include the same header.
- One natural sub-module: `sram_wait_counter`, a 4-bit counter with `clr`/`en` inputs and a `done` output when `cnt == WAIT_CYCLES-1`. Everything else lives in `sram_mem_responder`.

## Test plan
- Reset, then idle with no request:
  - `ready` = 1, `sram_we_n` = 1, `sram_dq_oe` = 0, `read_data` = 0.
- Write `0xDEADBEEF` to address 1028 with W = 3:
  - `sram_addr` = 2 for cycles 1..3 with `sram_dq_out` = `0xBEEF`;
  - `sram_addr` = 3 for cycles 4..6 with `sram_dq_out` = `0xDEAD`;
  - `sram_we_n` = 0 during cycles 1..6;
  - `ready` = 1 only in cycle 7.
- Read back address 1028 with the SRAM model returning the stored halves:
  - `read_data` = `0xDEADBEEF` in cycle 7;
  - `sram_dq_oe` = 0 throughout.
- `mem_read` and `mem_write` both asserted:
  - a write is performed;
  - `read_data` is unchanged from its prior value.
- Assert `rst` in cycle 4 of a write:
  - next cycle is IDLE, `sram_we_n` = 1, `sram_dq_oe` = 0;
  - a subsequent read completes normally in 7 cycles.
- W = 1, back-to-back reads of 1024 and 1032:
  - `ready` pulses in cycles 3 and 7;
  - `sram_addr` sequence 0,1 then 4,5.

Source files
------------

// File: rtl/sram_mem_responder_pkg.sv
// Shared definitions for the data-memory / SRAM interface.
package sram_mem_responder_pkg;

  localparam int unsigned SRAM_AW           = 18;
  localparam int unsigned SRAM_DW           = 16;
  localparam int unsigned WORD_IDX_W        = SRAM_AW - 1;
  localparam int unsigned CNT_W             = 4;
  localparam int unsigned DEFAULT_BASE_ADDR = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // SRAM word index of a byte address; wraps silently on truncation.
  function automatic logic [WORD_IDX_W-1:0] word_idx(input logic [31:0] address,
                                                     input logic [31:0] base);
    logic [31:0] offset;
    offset = address - base;
    return offset[WORD_IDX_W+1:2];
  endfunction

endpackage

// File: rtl/sram_mem_responder_wait_counter.sv
// Wait-state counter: counts cycles a 16-bit half is held on the SRAM bus.
module sram_wait_counter
  import sram_mem_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  logic [CNT_W-1:0] cnt;

  // Clear has priority over count enable.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Last wait cycle of the current half.
  assign done = (cnt == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_mem_responder.sv
// MEM-stage responder: moves one 32-bit word as two 16-bit SRAM halves.
module sram_mem_responder
  import sram_mem_responder_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n
);

  state_e                state;
  logic                  is_write;
  logic                  req;
  logic                  cnt_en;
  logic                  cnt_clr;
  logic                  cnt_done;
  logic [WORD_IDX_W-1:0] idx;

  assign req     = mem_read | mem_write;
  assign idx     = word_idx(address, 32'(BASE_ADDR));
  assign cnt_en  = (state == ST_LOW) || (state == ST_HIGH);
  assign cnt_clr = (state == ST_IDLE) || cnt_done;

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .done (cnt_done)
  );

  // Completion (or idle with nothing to do) releases the pipeline freeze.
  assign ready = ((state == ST_IDLE) && !req) || (state == ST_DONE);

  // Access sequencer with registered SRAM pins and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      is_write    <= 1'b0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state       <= ST_LOW;
            is_write    <= mem_write;
            sram_addr   <= {idx, 1'b0};
            sram_dq_out <= mem_write ? write_data[15:0] : '0;
            sram_dq_oe  <= mem_write;
            sram_we_n   <= ~mem_write;
          end
        end
        ST_LOW: begin
          if (cnt_done) begin
            state     <= ST_HIGH;
            sram_addr <= {idx, 1'b1};
            if (is_write) begin
              sram_dq_out <= write_data[31:16];
            end else begin
              read_data[15:0] <= sram_dq_in;
            end
          end
        end
        ST_HIGH: begin
          if (cnt_done) begin
            state       <= ST_DONE;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            if (!is_write) begin
              read_data[31:16] <= sram_dq_in;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Requester must hold its request steady while stalled.
  a_req_stable : assert property (@(posedge clk)
    (!rst && !ready) |=> $stable({mem_read, mem_write, address, write_data}));

endmodule

// File: tb/tb_sram_mem_responder.sv
// Self-checking bench for sram_mem_responder against a word-level memory model.
module tb_sram_mem_responder;

  localparam int unsigned W    = 3;
  localparam int unsigned BASE = 1024;

  logic        clk = 1'b0;
  logic        rst;

  // W = 3 instance
  logic        mem_read, mem_write;
  logic [31:0] address, write_data, read_data;
  logic        ready, sram_dq_oe, sram_we_n;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;

  // W = 1 instance
  logic        b_read, b_write;
  logic [31:0] b_address, b_write_data, b_read_data;
  logic        b_ready, b_dq_oe, b_we_n;
  logic [17:0] b_sram_addr;
  logic [15:0] b_dq_out, b_dq_in;

  // Physical SRAM array plus a bench-side preload port
  logic [15:0] sram [0:262143];
  logic        pre_we;
  logic [17:0] pre_addr;
  logic [15:0] pre_data;

  int checks = 0;
  int errors = 0;

  // Word-level reference: word index -> 32-bit value, and the expected read_data register
  logic [31:0] ref_words [int];
  logic [31:0] model_rd;

  always #5 clk = ~clk;

  sram_mem_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  sram_mem_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst), .mem_read(b_read), .mem_write(b_write),
    .address(b_address), .write_data(b_write_data), .read_data(b_read_data),
    .ready(b_ready), .sram_addr(b_sram_addr), .sram_dq_out(b_dq_out),
    .sram_dq_oe(b_dq_oe), .sram_dq_in(b_dq_in), .sram_we_n(b_we_n)
  );

  initial begin
    for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;
  end

  // Asynchronous SRAM approximated as write-on-clock while the strobe is low
  always @(posedge clk) begin
    if (!sram_we_n) sram[sram_addr] <= sram_dq_out;
    else if (pre_we) sram[pre_addr] <= pre_data;
  end

  assign sram_dq_in = sram[sram_addr];
  assign b_dq_in    = sram[b_sram_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - 32'(BASE);
    return int'((off / 32'd4) % 32'd131072);
  endfunction

  function automatic logic [31:0] ref_read(input int idx);
    if (ref_words.exists(idx)) return ref_words[idx];
    return 32'h0;
  endfunction

  // One full access on the W=3 instance; entered and left just after a rising edge in IDLE.
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd);
    int          idx;
    bit          half;
    logic [31:0] ea;
    logic [31:0] eh;
    idx        = word_of(addr);
    mem_write  = wr;
    mem_read   = rd;
    address    = addr;
    write_data = wdata;
    @(negedge clk);
    chk("cycle0_ready", 32'(ready), 32'd0);
    chk("cycle0_addr", 32'(sram_addr), 32'd0);
    for (int c = 1; c <= 2 * int'(W) + 1; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c <= 2 * int'(W)) begin
        half = (c > int'(W));
        ea   = 32'(idx) * 32'd2 + 32'(half);
        eh   = half ? (wdata >> 16) : (wdata & 32'h0000FFFF);
        chk("busy_ready", 32'(ready), 32'd0);
        chk("busy_sram_addr", 32'(sram_addr), ea);
        chk("busy_we_n", 32'(sram_we_n), wr ? 32'd0 : 32'd1);
        chk("busy_oe", 32'(sram_dq_oe), wr ? 32'd1 : 32'd0);
        if (wr) chk("busy_dq_out", 32'(sram_dq_out), eh);
      end else begin
        chk("done_ready", 32'(ready), 32'd1);
        chk("done_sram_addr", 32'(sram_addr), 32'd0);
        chk("done_we_n", 32'(sram_we_n), 32'd1);
        chk("done_oe", 32'(sram_dq_oe), 32'd0);
        chk("done_read_data", read_data, exp_rd);
      end
    end
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    model_rd  = exp_rd;
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [7];

  logic [31:0] w1_exp_addr  [8];
  bit          w1_exp_ready [8];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{1'b0, 1'b1, 32'd1028, 32'h00000000, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'd1036, 32'h12345678, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'd1036, 32'h00000000, 32'h12345678};
    vecs[4] = '{1'b0, 1'b1, 32'd1024, 32'h00000000, 32'h00000000};
    vecs[5] = '{1'b1, 1'b0, 32'd0,    32'hA5A55A5A, 32'h00000000};
    vecs[6] = '{1'b0, 1'b1, 32'd0,    32'h00000000, 32'hA5A55A5A};

    w1_exp_addr  = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd4, 32'd5, 32'd0};
    w1_exp_ready = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; address = '0; write_data = '0;
    b_read = 1'b0; b_write = 1'b0; b_address = '0; b_write_data = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    model_rd = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
    chk("rst_w1_ready", 32'(b_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);
      if (vecs[i].wr) ref_words[word_of(vecs[i].addr)] = vecs[i].wdata;
    end

    // Reset in cycle 4 of a write
    mem_write = 1'b1; address = 32'd1040; write_data = 32'h11112222;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_oe", 32'(sram_dq_oe), 32'd0);
    chk("abort_sram_addr", 32'(sram_addr), 32'd0);
    chk("abort_read_data", read_data, 32'd0);
    @(posedge clk);
    #1;
    model_rd = 32'h0;
    access(1'b0, 1'b1, 32'd1028, 32'h0, ref_read(word_of(32'd1028)));

    // Randomized traffic against the word-level model
    for (int n = 0; n < 40; n++) begin
      int unsigned op;
      int unsigned k;
      logic [31:0] a;
      logic [31:0] d;
      bit          is_wr;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("idle_ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
      end
      op    = $urandom_range(0, 2);
      k     = $urandom_range(64, 191);
      a     = 32'(BASE) + 32'(k) * 32'd4;
      d     = $urandom;
      is_wr = (op != 0);
      access(is_wr, op != 1, a, d, is_wr ? model_rd : ref_read(word_of(a)));
      if (is_wr) ref_words[word_of(a)] = d;
    end

    // Preload SRAM for the W=1 reads
    pre_we = 1'b1;
    pre_addr = 18'd0; pre_data = 16'h1357; @(posedge clk); #1;
    pre_addr = 18'd1; pre_data = 16'h2468; @(posedge clk); #1;
    pre_addr = 18'd4; pre_data = 16'hACE0; @(posedge clk); #1;
    pre_addr = 18'd5; pre_data = 16'hBDF1; @(posedge clk); #1;
    pre_we = 1'b0;

    // W=1 back-to-back reads of 1024 then 1032
    b_read = 1'b1; b_address = 32'd1024;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) b_address = 32'd1032;
      @(negedge clk);
      chk("w1_ready", 32'(b_ready), 32'(w1_exp_ready[c]));
      chk("w1_sram_addr", 32'(b_sram_addr), w1_exp_addr[c]);
      chk("w1_oe", 32'(b_dq_oe), 32'd0);
      if (c == 3) chk("w1_read_data_a", b_read_data, 32'h24681357);
      if (c == 7) chk("w1_read_data_b", b_read_data, 32'hBDF1ACE0);
      @(posedge clk);
      #1;
    end
    b_read = 1'b0;
    @(negedge clk);
    chk("w1_idle_ready", 32'(b_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
